wb_burst_master: RTL and testbench
==================================

Name: wb_burst_master

Overview:
- Wishbone B3 burst initiator that drives wb_sdram_ctrl (or any B3 responder) from a simple request interface.
- Issues incrementing-linear bursts of 1..BURST 32-bit words, reads or writes.
- Handles rty by backing off and resuming at the current beat; handles err by aborting.
- Sits in front of the SDRAM controller for the openvga framebuffer fetch and blit paths.

Parameters:
ADDRESS, 23, word-address width (23 = 8Mx32)
BURST, 16, maximum beats per request (power of two, 1..16)
RETRY_MAX, 255, consecutive rty responses without an ack before abort

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  synchronous reset, active-high
req_i  in  1  request strobe, accepted when req_rdy_o=1
req_we_i  in  1  1=write burst, 0=read burst
req_adr_i  in  ADDRESS  first word address
req_len_i  in  5  beat count 0..BURST
req_rdy_o  out  1  idle, ready for request
done_o  out  1  one-cycle pulse at end of request
err_o  out  1  one-cycle pulse with done_o on abort
wr_dat_i  in  32  write data (show-ahead source)
wr_sel_i  in  4  write byte enables
wr_rd_o  out  1  pop strobe, one per acked write beat
rd_dat_o  out  32  read data
rd_vld_o  out  1  read data valid
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_we_o  out  1  write enable
wb_ack_i  in  1  ack
wb_rty_i  in  1  retry
wb_err_i  in  1  error
wb_cti_o  out  3  cycle type
wb_bte_o  out  2  burst type, tied 2'b00
wb_adr_o  out  ADDRESS  word address
wb_sel_o  out  4  byte select
wb_dat_o  out  32  write data

Behaviour:
- Single clock domain (wb_clk_i). Reset is synchronous, active-high (wb_rst_i).
- Reset values: state IDLE; cyc, stb, we, done_o, err_o, rd_vld_o, wr_rd_o = 0; cti = 000; adr = 0; req_rdy_o = 1.
- Reset mid-burst: cyc/stb drop at the next edge. No done_o pulse is generated.
- FSM states: IDLE, BUS, BACKOFF, FIN.
- IDLE:
  - req_rdy_o = 1.
  - On req_i, latch we, adr, len. Beat counter = 0; retry counter = 0.
  - len = 0: go to FIN; the bus is never touched.
  - len > BURST: clamp to BURST.
  - Otherwise go to BUS; cyc/stb are registered and assert on the next cycle.
- BUS:
  - cyc = stb = 1.
  - adr = base + beat, modulo 2^ADDRESS (wraps at top of memory).
  - cti = 000 if len = 1; otherwise 010 for non-final beats and 111 on the final beat.
  - bte = 00.
- ack:
  - Beat counter increments; retry counter clears.
  - Next address and cti are presented on the following cycle (registered, one beat per ack).
  - On the final ack, cyc/stb = 0 next cycle and go to FIN.
- rty (no ack):
  - Drop cyc/stb for exactly one cycle (BACKOFF) and increment the retry counter.
  - Then return to BUS at the same beat, with cti recomputed from the remaining beats.
  - When the retry counter reaches RETRY_MAX, abort to FIN with error.
- err: drop cyc/stb next cycle and go to FIN with error. Beats already transferred stand.
- ack and rty together: ack wins. ack/err together: err wins.
- FIN: pulse done_o for one cycle (err_o as well if aborted), then return to IDLE. req_rdy_o returns to 1 the cycle after done_o.
- Write path:
  - wb_dat_o = wr_dat_i and wb_sel_o = wr_sel_i, both combinational.
  - wr_rd_o = wb_ack_i & BUS & we, same cycle as the ack.
  - The source must hold valid data throughout the burst.
  - wb_sel_o = 4'b1111 on reads.
- Read path: rd_dat_o and rd_vld_o are registered from wb_dat_i and ack&!we. Latency is 1 cycle. Exactly len pulses per successful read.
- Requests are not accepted outside IDLE (req_i is ignored).

Decomposition:
- Shared package wb_pkg holds:
  - CTI_CLASSIC = 3'b000, CTI_INCR = 3'b010, CTI_EOB = 3'b111;
  - BTE_LINEAR = 2'b00;
  - the FSM state encoding.
- Single module, no sub-modules. The cti/address generator is small enough to stay inline.

Test Plan:
- Write burst: adr=0, len=16, responder acks every cycle → cti 010 ×15 then 111; adr 0..15; 16 wr_rd_o pulses; done_o one cycle after the last ack; err_o=0.
- Read burst: adr=0, len=16, then single read at adr=0 with len=1 → 16 rd_vld_o pulses matching the written data; the single read uses cti=000 and returns the first word.
- Responder asserts rty for the first 40 cycles (SDRAM init) → repeated BACKOFF gaps of one cycle with cyc low; burst then completes from beat 0; no err_o.
- rty on beat 5 of a 16-beat read → cyc low one cycle, resume at adr base+5; total rd_vld_o = 16.
- err on beat 3, and separately 255 consecutive rty → cyc drops, done_o and err_o pulse together, req_rdy_o = 1 next cycle.
- Boundaries and reset:
  - adr = 2^23−2, len = 4 → adr sequence 7FFFFE, 7FFFFF, 000000, 000001.
  - len = 0 → done_o with no cyc.
  - wb_rst_i asserted mid-burst → cyc/stb = 0 next edge, no done_o.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone B3 encodings and the burst-master FSM state type.
package wb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUS     = 2'd1,
      ST_BACKOFF = 2'd2,
      ST_FIN     = 2'd3
   } state_t;

   // Cycle type for the beat about to be presented, from the remaining count.
   function automatic logic [2:0] beat_cti(input logic [4:0] len, input logic [4:0] beat);
      logic [4:0] remain;
      remain = len - beat;
      if (len == 5'd1)
         beat_cti = CTI_CLASSIC;
      else if (remain == 5'd1)
         beat_cti = CTI_EOB;
      else
         beat_cti = CTI_INCR;
   endfunction

endpackage

// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst initiator: 1..BURST word reads or writes,
// backs off one cycle on rty and resumes at the same beat, aborts on err.
module wb_burst_master
   import wb_pkg::*;
#(
   parameter int ADDRESS   = 23,
   parameter int BURST     = 16,
   parameter int RETRY_MAX = 255
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               req_i,
   input  logic               req_we_i,
   input  logic [ADDRESS-1:0] req_adr_i,
   input  logic [4:0]         req_len_i,
   output logic               req_rdy_o,
   output logic               done_o,
   output logic               err_o,
   input  logic [31:0]        wr_dat_i,
   input  logic [3:0]         wr_sel_i,
   output logic               wr_rd_o,
   output logic [31:0]        rd_dat_o,
   output logic               rd_vld_o,
   output logic               wb_cyc_o,
   output logic               wb_stb_o,
   output logic               wb_we_o,
   input  logic               wb_ack_i,
   input  logic               wb_rty_i,
   input  logic               wb_err_i,
   input  logic [31:0]        wb_dat_i,
   output logic [2:0]         wb_cti_o,
   output logic [1:0]         wb_bte_o,
   output logic [ADDRESS-1:0] wb_adr_o,
   output logic [3:0]         wb_sel_o,
   output logic [31:0]        wb_dat_o
);

   localparam int RW = $clog2(RETRY_MAX + 1);

   state_t             r_state, w_state_nxt;
   logic               r_we, r_err, r_rd_vld;
   logic [ADDRESS-1:0] r_base;
   logic [4:0]         r_len, r_beat, w_len_req;
   logic [RW-1:0]      r_retry;
   logic [RW:0]        w_retry_inc;
   logic [31:0]        r_rd_dat;
   logic               w_bus, w_ack, w_rty, w_err, w_last, w_abort;

   // err beats ack, ack beats rty
   assign w_bus       = (r_state == ST_BUS);
   assign w_err       = w_bus & wb_err_i;
   assign w_ack       = w_bus & wb_ack_i & ~wb_err_i;
   assign w_rty       = w_bus & wb_rty_i & ~wb_ack_i & ~wb_err_i;
   assign w_last      = ((r_beat + 5'd1) == r_len);
   assign w_retry_inc = {1'b0, r_retry} + {{RW{1'b0}}, 1'b1};
   assign w_abort     = (w_retry_inc >= (RW+1)'(RETRY_MAX));
   assign w_len_req   = (req_len_i > 5'(BURST)) ? 5'(BURST) : req_len_i;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (req_i) w_state_nxt = (w_len_req == 5'd0) ? ST_FIN : ST_BUS;
         ST_BUS: begin
            if (w_err)
               w_state_nxt = ST_FIN;
            else if (w_ack) begin
               if (w_last) w_state_nxt = ST_FIN;
            end else if (w_rty)
               w_state_nxt = w_abort ? ST_FIN : ST_BACKOFF;
         end
         ST_BACKOFF: w_state_nxt = ST_BUS;
         ST_FIN:     w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_we     <= 1'b0;
         r_err    <= 1'b0;
         r_beat   <= 5'd0;
         r_retry  <= '0;
         r_rd_vld <= 1'b0;
      end else begin
         r_rd_vld <= w_ack & ~r_we;
         if (r_state == ST_IDLE && req_i) begin
            r_we    <= req_we_i;
            r_err   <= 1'b0;
            r_beat  <= 5'd0;
            r_retry <= '0;
         end else if (w_err) begin
            r_err <= 1'b1;
         end else if (w_ack) begin
            r_beat  <= r_beat + 5'd1;
            r_retry <= '0;
         end else if (w_rty) begin
            r_retry <= w_retry_inc[RW-1:0];
            if (w_abort) r_err <= 1'b1;
         end
      end
   end

   // Request fields and read data carry no reset; they are qualified by state/valid.
   always_ff @(posedge wb_clk_i) begin
      if (r_state == ST_IDLE && req_i) begin
         r_base <= req_adr_i;
         r_len  <= w_len_req;
      end
      if (w_ack) r_rd_dat <= wb_dat_i;
   end

   always_comb begin
      req_rdy_o = (r_state == ST_IDLE);
      done_o    = (r_state == ST_FIN);
      err_o     = (r_state == ST_FIN) & r_err;
      wb_cyc_o  = w_bus;
      wb_stb_o  = w_bus;
      wb_we_o   = w_bus & r_we;
      wb_cti_o  = w_bus ? beat_cti(r_len, r_beat) : CTI_CLASSIC;
      wb_bte_o  = BTE_LINEAR;
      wb_adr_o  = w_bus ? (r_base + ADDRESS'(r_beat)) : '0;
      wb_sel_o  = r_we ? wr_sel_i : 4'b1111;
      wb_dat_o  = wr_dat_i;
      wr_rd_o   = w_ack & r_we;
      rd_dat_o  = r_rd_dat;
      rd_vld_o  = r_rd_vld;
   end

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master against a behavioural B3 responder.
module tb_wb_burst_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_i = 1'b0, req_we_i = 1'b0;
   logic [22:0] req_adr_i = '0;
   logic [4:0]  req_len_i = '0;
   logic        req_rdy_o, done_o, err_o, wr_rd_o, rd_vld_o;
   logic [31:0] wr_dat_i = '0, rd_dat_o, wb_dat_i = '0, wb_dat_o;
   logic [3:0]  wr_sel_i = 4'hF, wb_sel_o;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic        wb_ack_i = 1'b0, wb_rty_i = 1'b0, wb_err_i = 1'b0;
   logic [2:0]  wb_cti_o;
   logic [1:0]  wb_bte_o;
   logic [22:0] wb_adr_o;

   always #5 clk = ~clk;

   wb_burst_master #(.ADDRESS(23), .BURST(16), .RETRY_MAX(255)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .req_i(req_i), .req_we_i(req_we_i),
      .req_adr_i(req_adr_i), .req_len_i(req_len_i), .req_rdy_o(req_rdy_o),
      .done_o(done_o), .err_o(err_o), .wr_dat_i(wr_dat_i), .wr_sel_i(wr_sel_i),
      .wr_rd_o(wr_rd_o), .rd_dat_o(rd_dat_o), .rd_vld_o(rd_vld_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_ack_i(wb_ack_i), .wb_rty_i(wb_rty_i), .wb_err_i(wb_err_i),
      .wb_dat_i(wb_dat_i), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
      .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o)
   );

   typedef struct {
      logic [22:0] adr;
      logic [2:0]  cti;
      logic        we;
      logic [31:0] dat;
   } beat_t;
   typedef struct {
      logic err;
      logic bus;
   } done_t;

   beat_t       exp_bus[$];
   logic [31:0] exp_rd[$];
   done_t       exp_done[$];
   logic [31:0] ref_mem[int];
   logic [31:0] mem[int];
   logic [31:0] wr_src[16];

   int checks = 0, errors = 0;
   int cyc_n = 0, t0 = 0, last_resp = 0;
   int acks = 0, rtys = 0, backoffs = 0, wr_pops = 0, done_cnt = 0, wr_ptr = 0;
   bit done_seen = 0, saw_cyc = 0, rdy_chk = 0, gap_chk = 0, resume_pend = 0;
   logic [22:0] resume_adr = '0;

   // responder policy
   bit          rty_all = 0, err_en = 0, rty_once = 0;
   int          rty_cycles = 0;
   logic [22:0] err_adr = '0, rty_adr = '0;

   task automatic chk(input bit ok, input string nm, input longint act, input longint req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [2:0] exp_cti(input int len, input int b);
      if (len == 1) return 3'b000;
      if (b == len - 1) return 3'b111;
      return 3'b010;
   endfunction

   // responder: decides ack/rty/err for the cycle stb is presented
   always @(negedge clk) begin
      wb_ack_i = 1'b0; wb_rty_i = 1'b0; wb_err_i = 1'b0;
      if (wb_cyc_o && wb_stb_o) begin
         if (rty_all || (cyc_n - t0) < rty_cycles) wb_rty_i = 1'b1;
         else if (err_en && wb_adr_o == err_adr) wb_err_i = 1'b1;
         else if (rty_once && wb_adr_o == rty_adr) begin
            wb_rty_i = 1'b1;
            rty_once = 0;
         end else begin
            wb_ack_i = 1'b1;
            if (wb_we_o) mem[int'(wb_adr_o)] = wb_dat_o;
            else wb_dat_i = mem.exists(int'(wb_adr_o)) ? mem[int'(wb_adr_o)]
                                                      : (32'hDEAD0000 | {16'd0, wb_adr_o[15:0]});
         end
      end
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      beat_t b;
      done_t d;
      #1;
      cyc_n++;
      if (wb_cyc_o) saw_cyc = 1;
      if (gap_chk) begin
         chk(!wb_cyc_o && !wb_stb_o, "backoff_gap_cyc", wb_cyc_o, 0);
         if (!wb_cyc_o) backoffs++;
         gap_chk = 0;
      end
      if (wb_cyc_o && wb_stb_o) begin
         if (resume_pend) begin
            chk(wb_adr_o == resume_adr, "resume_adr", wb_adr_o, resume_adr);
            resume_pend = 0;
         end
         chk(wb_bte_o == 2'b00, "bte", wb_bte_o, 0);
         chk(wr_rd_o == (wb_we_o & wb_ack_i & ~wb_err_i), "wr_rd_o", wr_rd_o, wb_we_o & wb_ack_i & ~wb_err_i);
         if (wb_ack_i && !wb_err_i) begin
            acks++;
            last_resp = cyc_n;
            if (exp_bus.size() == 0) chk(0, "unexpected_beat", wb_adr_o, 0);
            else begin
               b = exp_bus.pop_front();
               chk(wb_adr_o == b.adr, "beat_adr", wb_adr_o, b.adr);
               chk(wb_cti_o == b.cti, "beat_cti", wb_cti_o, b.cti);
               chk(wb_we_o == b.we, "beat_we", wb_we_o, b.we);
               if (b.we) begin
                  chk(wb_dat_o == b.dat, "wr_dat", wb_dat_o, b.dat);
                  chk(wb_sel_o == 4'hF, "wr_sel", wb_sel_o, 4'hF);
               end else
                  chk(wb_sel_o == 4'hF, "rd_sel", wb_sel_o, 4'hF);
            end
         end else if (wb_err_i) begin
            last_resp = cyc_n;
         end else if (wb_rty_i) begin
            rtys++;
            last_resp = cyc_n;
            gap_chk = 1;
            resume_pend = 1;
            resume_adr = wb_adr_o;
         end
      end else if (wr_rd_o) chk(0, "wr_rd_idle", wr_rd_o, 0);
      if (wr_rd_o) begin
         wr_pops++;
         if (wr_ptr < 15) wr_ptr++;
         wr_dat_i = wr_src[wr_ptr];
      end
      if (rd_vld_o) begin
         if (exp_rd.size() == 0) chk(0, "unexpected_rd_vld", rd_dat_o, 0);
         else begin
            logic [31:0] e;
            e = exp_rd.pop_front();
            chk(rd_dat_o == e, "rd_dat", rd_dat_o, e);
         end
      end
      if (rdy_chk) begin
         chk(req_rdy_o == 1'b1, "req_rdy_after_done", req_rdy_o, 1);
         rdy_chk = 0;
      end
      if (done_o) begin
         done_cnt++;
         done_seen = 1;
         rdy_chk = 1;
         if (exp_done.size() == 0) chk(0, "unexpected_done", done_o, 0);
         else begin
            d = exp_done.pop_front();
            chk(err_o == d.err, "done_err", err_o, d.err);
            chk(!wb_cyc_o, "cyc_at_done", wb_cyc_o, 0);
            if (d.bus) chk(cyc_n == last_resp + 1, "done_latency", cyc_n - last_resp, 1);
         end
      end else if (err_o) chk(0, "err_without_done", err_o, 0);
   end

   task automatic load_src(input logic [22:0] adr, input int len);
      for (int i = 0; i < 16; i++) wr_src[i] = 32'h5A000000 ^ {9'd0, adr + 23'(i)} ^ (32'(len) << 24);
      wr_ptr   = 0;
      wr_dat_i = wr_src[0];
   endtask

   task automatic push_beats(input bit we, input logic [22:0] adr, input int len, input int nb);
      beat_t b;
      logic [22:0] a;
      for (int i = 0; i < nb; i++) begin
         a = adr + 23'(i);
         b.adr = a; b.cti = exp_cti(len, i); b.we = we; b.dat = we ? wr_src[i] : 32'h0;
         exp_bus.push_back(b);
         if (we) ref_mem[int'(a)] = wr_src[i];
         else begin
            if (!ref_mem.exists(int'(a))) ref_mem[int'(a)] = 32'hDEAD0000 | {16'd0, a[15:0]};
            exp_rd.push_back(ref_mem[int'(a)]);
         end
      end
   endtask

   task automatic issue(input bit we, input logic [22:0] adr, input int len);
      @(posedge clk); #2;
      chk(req_rdy_o == 1'b1, "req_rdy_idle", req_rdy_o, 1);
      req_i = 1'b1; req_we_i = we; req_adr_i = adr; req_len_i = 5'(len);
      @(posedge clk); #2;
      req_i = 1'b0;
   endtask

   // ok_beats < 0 means every beat of the (clamped) burst is acked
   task automatic do_req(input bit we, input logic [22:0] adr, input int len,
                         input int ok_beats, input bit exp_err);
      int    L, nb;
      done_t d;
      L  = (len > 16) ? 16 : len;
      nb = (ok_beats < 0) ? L : ok_beats;
      load_src(adr, len);
      push_beats(we, adr, L, nb);
      d.err = exp_err; d.bus = (L != 0);
      exp_done.push_back(d);
      acks = 0; rtys = 0; backoffs = 0; wr_pops = 0;
      resume_pend = 0; saw_cyc = 0; done_seen = 0; t0 = cyc_n;
      issue(we, adr, len);
      for (int i = 0; i < 3000 && !done_seen; i++) @(posedge clk);
      if (!done_seen) chk(0, "done_timeout", 0, 1);
      @(posedge clk); @(posedge clk); #2;
      chk(exp_bus.size() == 0, "beats_left", exp_bus.size(), 0);
      chk(exp_rd.size() == 0, "reads_left", exp_rd.size(), 0);
      exp_bus.delete(); exp_rd.delete(); exp_done.delete();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk); #2;
      chk(req_rdy_o == 1'b1, "rst_req_rdy", req_rdy_o, 1);
      chk(wb_cyc_o == 1'b0 && wb_stb_o == 1'b0, "rst_cyc_stb", {wb_cyc_o, wb_stb_o}, 0);
      chk(wb_we_o == 1'b0, "rst_we", wb_we_o, 0);
      chk(done_o == 1'b0 && err_o == 1'b0, "rst_done_err", {done_o, err_o}, 0);
      chk(rd_vld_o == 1'b0 && wr_rd_o == 1'b0, "rst_vld_rd", {rd_vld_o, wr_rd_o}, 0);
      chk(wb_cti_o == 3'b000 && wb_adr_o == 23'd0, "rst_cti_adr", {wb_cti_o, wb_adr_o}, 0);
      @(posedge clk); #2 rst = 1'b0;

      // full write burst then read it back, then a classic single read
      do_req(1'b1, 23'd0, 16, -1, 1'b0);
      chk(acks == 16, "wr16_acks", acks, 16);
      chk(wr_pops == 16, "wr16_pops", wr_pops, 16);
      do_req(1'b0, 23'd0, 16, -1, 1'b0);
      chk(acks == 16, "rd16_acks", acks, 16);
      do_req(1'b0, 23'd0, 1, -1, 1'b0);
      chk(acks == 1, "rd1_acks", acks, 1);

      // responder busy for 40 cycles: repeated one-cycle backoffs, then normal burst
      rty_cycles = 40;
      do_req(1'b1, 23'h100, 8, -1, 1'b0);
      rty_cycles = 0;
      chk(rtys > 1, "init_rty_seen", rtys, 2);
      chk(backoffs == rtys, "init_backoffs", backoffs, rtys);
      chk(wr_pops == 8, "init_pops", wr_pops, 8);

      // single rty on beat 5 of a 16-beat read
      rty_once = 1; rty_adr = 23'd5;
      do_req(1'b0, 23'd0, 16, -1, 1'b0);
      chk(rtys == 1 && backoffs == 1, "beat5_rty", {rtys[7:0], backoffs[7:0]}, 16'h0101);
      chk(acks == 16, "beat5_acks", acks, 16);

      // err on beat 3 aborts with three beats transferred
      err_en = 1; err_adr = 23'h203;
      do_req(1'b1, 23'h200, 16, 3, 1'b1);
      err_en = 0;
      chk(acks == 3 && wr_pops == 3, "err_beats", {acks[7:0], wr_pops[7:0]}, 16'h0303);

      // persistent rty aborts after RETRY_MAX responses
      rty_all = 1;
      do_req(1'b1, 23'h300, 4, 0, 1'b1);
      rty_all = 0;
      chk(rtys == 255, "abort_rty_count", rtys, 255);
      chk(acks == 0, "abort_acks", acks, 0);

      // address wrap at top of memory, written then read back
      do_req(1'b1, 23'h7FFFFE, 4, -1, 1'b0);
      do_req(1'b0, 23'h7FFFFE, 4, -1, 1'b0);
      chk(acks == 4, "wrap_rd_acks", acks, 4);

      // zero length never touches the bus
      do_req(1'b0, 23'h40, 0, -1, 1'b0);
      chk(saw_cyc == 1'b0, "len0_no_cyc", saw_cyc, 0);

      // over-length request clamps to 16 beats
      do_req(1'b1, 23'h400, 20, -1, 1'b0);
      chk(acks == 16, "clamp_acks", acks, 16);

      // reset in the middle of a burst
      begin
         int dn;
         load_src(23'h500, 16);
         push_beats(1'b1, 23'h500, 16, 16);
         acks = 0; dn = done_cnt;
         issue(1'b1, 23'h500, 16);
         for (int i = 0; i < 200 && acks < 5; i++) @(posedge clk);
         chk(acks >= 5, "midrst_started", acks, 5);
         @(posedge clk); #2 rst = 1'b1;
         @(posedge clk);
         @(negedge clk); #3;
         chk(!wb_cyc_o && !wb_stb_o, "midrst_cyc_drop", {wb_cyc_o, wb_stb_o}, 0);
         exp_bus.delete();
         @(posedge clk); #2 rst = 1'b0;
         repeat (4) @(posedge clk);
         #2;
         chk(req_rdy_o == 1'b1, "midrst_rdy", req_rdy_o, 1);
         chk(done_cnt == dn, "midrst_no_done", done_cnt - dn, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
